program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Writer-side counterpart of the control unit's program fetch.
- Receives a byte stream from the UART receiver and assembles 16-bit instruction words, high byte first.
- Writes each word into program memory at consecutive addresses starting at 0.
- Holds the CPU in reset while loading and releases it once the load completes.

Parameters:
- NB_INSTRUCTION, 16, instruction word width; must equal 2*NB_BYTE.
- NB_ADDR, 11, program memory address width.
- NB_OPCODE, 5, opcode field width (MSBs of the word).
- NB_BYTE, 8, width of a received byte.

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- i_start  in  1  single-cycle pulse that begins a load.
- i_rx_data  in  NB_BYTE  received byte.
- i_rx_valid  in  1  single-cycle strobe; i_rx_data valid.
- o_wr_enb_prog  out  1  program memory write enable.
- o_wr_addr  out  NB_ADDR  program memory write address.
- o_wr_data  out  NB_INSTRUCTION  program memory write data.
- o_cpu_reset  out  1  high holds the CPU (control unit PC) in reset.
- o_busy  out  1  load in progress.
- o_done  out  1  load finished; CPU running.
- o_overflow  out  1  sticky: memory filled without a halt word.
- o_overrun  out  1  sticky: byte dropped during a write cycle.

Behaviour:
- Reset values:
  - state IDLE.
  - o_wr_addr 0, o_wr_data 0, o_wr_enb_prog 0.
  - o_cpu_reset 1.
  - o_busy 0, o_done 0, o_overflow 0, o_overrun 0.
- All outputs are registered.
- States: IDLE, RX_HIGH, RX_LOW, WRITE, DONE. o_busy=1 in RX_HIGH, RX_LOW and WRITE.
- IDLE:
  - i_rx_valid is ignored.
  - i_start -> RX_HIGH next cycle; address counter <= 0; o_overflow, o_overrun <= 0.
- RX_HIGH: on i_rx_valid, latch i_rx_data into word[15:8] -> RX_LOW.
- RX_LOW: on i_rx_valid, latch i_rx_data into word[7:0] -> WRITE.
- WRITE (exactly one cycle):
  - o_wr_enb_prog=1, o_wr_addr=current address, o_wr_data=assembled word.
  - Halt word is word[NB_INSTRUCTION-1 -: NB_OPCODE]==0. It is written to memory, then state -> DONE.
  - Else, if address == 2^NB_ADDR-1: o_overflow<=1 -> DONE.
  - Else: address+1 -> RX_HIGH.
- Timing: the write enable pulse occurs the cycle after the low byte's i_rx_valid. Latency is 1 cycle from low byte to write.
- i_rx_valid during WRITE: byte dropped, o_overrun<=1. The write still completes normally.
- DONE:
  - o_done=1 and o_cpu_reset=0, both asserted the cycle after WRITE.
  - i_rx_valid is ignored.
  - i_start -> RX_HIGH with the same actions as from IDLE, and additionally o_cpu_reset<=1, o_done<=0.
- o_cpu_reset=1 in every state except DONE.
- i_start in RX_HIGH, RX_LOW or WRITE: ignored, no restart.
- i_rx_valid and i_start in the same cycle in IDLE/DONE: start taken, byte ignored.
- i_reset mid-load: immediate return to IDLE with reset values. Partial memory contents are not cleared. CPU remains in reset.
- Address counter wraps never; saturation is handled via o_overflow.

Decomposition:
- Shared package (bip_pkg):
  - state encoding constants: IDLE=0, RX_HIGH=1, RX_LOW=2, WRITE=3, DONE=4, width 3.
  - OPC_HALT = 5'b00000.
  - default widths NB_INSTRUCTION, NB_ADDR, NB_OPCODE.
- Single flat module; no sub-module. The byte assembler is two registers inside the FSM.

Test Plan:
- Load three words:
  - Stimulus: i_start, then bytes 08 05, 10 03, 18 01, 00 00.
  - Response: four write pulses, (addr,data) = (0,0805), (1,1003), (2,1801), (3,0000).
  - Response: o_done=1 and o_cpu_reset=0 the cycle after the 4th write; o_overflow=0.
- Overflow with NB_ADDR=2:
  - Stimulus: five non-halt words 0801.
  - Response: writes at addr 0..3, then DONE with o_overflow=1; fifth word never written.
- Overrun:
  - Stimulus: i_rx_valid on the WRITE cycle.
  - Response: o_overrun=1 sticky; next accepted byte becomes the high byte; the write is unaffected.
- Reset mid-load:
  - Stimulus: after bytes 08 05 10 (one word written), assert i_reset.
  - Response: next cycle IDLE, o_wr_addr=0, o_cpu_reset=1, no further writes.
  - Follow-up: new i_start plus a halt word writes to addr 0.
- Start while busy:
  - Stimulus: i_start in RX_LOW.
  - Response: ignored; load continues at the same address.
- Reload from DONE:
  - Stimulus: i_start in DONE.
  - Response: o_cpu_reset=1 and o_done=0 next cycle; the next halt word is written at addr 0.

Source files
------------

// File: rtl/bip_pkg.sv
// Shared definitions for the BIP program loader: state encoding,
// halt opcode and default field widths.
package bip_pkg;

  localparam int NB_INSTRUCTION = 16;
  localparam int NB_ADDR        = 11;
  localparam int NB_OPCODE      = 5;
  localparam int NB_BYTE        = 8;

  localparam logic [4:0] OPC_HALT = 5'b00000;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RX_HIGH = 3'd1,
    RX_LOW  = 3'd2,
    WRITE   = 3'd3,
    DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/program_loader.sv
// Program loader: assembles 16-bit words (high byte first) from the UART
// byte stream, writes them to program memory from address 0 and holds the
// CPU in reset until a halt word has been written or memory is full.
module program_loader #(
  parameter int NB_INSTRUCTION = bip_pkg::NB_INSTRUCTION,
  parameter int NB_ADDR        = bip_pkg::NB_ADDR,
  parameter int NB_OPCODE      = bip_pkg::NB_OPCODE,
  parameter int NB_BYTE        = bip_pkg::NB_BYTE
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_start,
  input  logic [NB_BYTE-1:0]        i_rx_data,
  input  logic                      i_rx_valid,
  output logic                      o_wr_enb_prog,
  output logic [NB_ADDR-1:0]        o_wr_addr,
  output logic [NB_INSTRUCTION-1:0] o_wr_data,
  output logic                      o_cpu_reset,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_overflow,
  output logic                      o_overrun
);

  import bip_pkg::*;

  state_t                    state;
  state_t                    next_state;
  logic [NB_BYTE-1:0]        high_byte;

  logic [NB_BYTE-1:0]        high_byte_d;
  logic [NB_ADDR-1:0]        wr_addr_d;
  logic [NB_INSTRUCTION-1:0] wr_data_d;
  logic                      wr_enb_d;
  logic                      cpu_reset_d;
  logic                      busy_d;
  logic                      done_d;
  logic                      overflow_d;
  logic                      overrun_d;

  logic                      is_halt;
  logic                      addr_at_max;

  // The word being written sits in o_wr_data; the address counter is o_wr_addr.
  assign is_halt     = (o_wr_data[NB_INSTRUCTION-1 -: NB_OPCODE] == NB_OPCODE'(OPC_HALT));
  assign addr_at_max = &o_wr_addr;

  // State register.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: byte sequencing and end-of-load decision in WRITE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: begin
        if (i_start) next_state = RX_HIGH;
      end
      RX_HIGH: begin
        if (i_rx_valid) next_state = RX_LOW;
      end
      RX_LOW: begin
        if (i_rx_valid) next_state = WRITE;
      end
      WRITE: begin
        if (is_halt || addr_at_max) next_state = DONE;
        else                        next_state = RX_HIGH;
      end
      default: next_state = IDLE;
    endcase
  end

  // Output logic: next values of every registered output, derived from the
  // current state, the inputs and the state being entered.
  always_comb begin
    high_byte_d = high_byte;
    wr_addr_d   = o_wr_addr;
    wr_data_d   = o_wr_data;
    overflow_d  = o_overflow;
    overrun_d   = o_overrun;
    case (state)
      IDLE, DONE: begin
        if (i_start) begin
          wr_addr_d  = '0;
          overflow_d = 1'b0;
          overrun_d  = 1'b0;
        end
      end
      RX_HIGH: begin
        if (i_rx_valid) high_byte_d = i_rx_data;
      end
      RX_LOW: begin
        if (i_rx_valid) wr_data_d = {high_byte, i_rx_data};
      end
      WRITE: begin
        if (i_rx_valid) overrun_d = 1'b1;
        if (!is_halt) begin
          if (addr_at_max) overflow_d = 1'b1;
          else             wr_addr_d  = o_wr_addr + NB_ADDR'(1);
        end
      end
      default: begin
        high_byte_d = high_byte;
      end
    endcase
    wr_enb_d    = (next_state == WRITE);
    busy_d      = (next_state == RX_HIGH) || (next_state == RX_LOW) || (next_state == WRITE);
    done_d      = (next_state == DONE);
    cpu_reset_d = (next_state != DONE);
  end

  // Output and datapath registers.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      high_byte     <= '0;
      o_wr_addr     <= '0;
      o_wr_data     <= '0;
      o_wr_enb_prog <= 1'b0;
      o_cpu_reset   <= 1'b1;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_overflow    <= 1'b0;
      o_overrun     <= 1'b0;
    end else begin
      high_byte     <= high_byte_d;
      o_wr_addr     <= wr_addr_d;
      o_wr_data     <= wr_data_d;
      o_wr_enb_prog <= wr_enb_d;
      o_cpu_reset   <= cpu_reset_d;
      o_busy        <= busy_d;
      o_done        <= done_d;
      o_overflow    <= overflow_d;
      o_overrun     <= overrun_d;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader: two instances (11-bit and 2-bit address)
// share one stimulus stream; a transaction-level model predicts writes and
// status, and a monitor compares them after every clock edge.
module tb_program_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        rxValid = 1'b0;
  logic [7:0]  rxData = 8'h00;

  logic        wrEnA, cpuResetA, busyA, doneA, overflowA, overrunA;
  logic [10:0] wrAddrA;
  logic [15:0] wrDataA;
  logic        wrEnB, cpuResetB, busyB, doneB, overflowB, overrunB;
  logic [1:0]  wrAddrB;
  logic [15:0] wrDataB;

  int tests = 0;
  int failures = 0;

  always #5 clock = ~clock;

  program_loader dutA (
    .i_clock(clock), .i_reset(reset), .i_start(start),
    .i_rx_data(rxData), .i_rx_valid(rxValid),
    .o_wr_enb_prog(wrEnA), .o_wr_addr(wrAddrA), .o_wr_data(wrDataA),
    .o_cpu_reset(cpuResetA), .o_busy(busyA), .o_done(doneA),
    .o_overflow(overflowA), .o_overrun(overrunA)
  );

  program_loader #(.NB_ADDR(2)) dutB (
    .i_clock(clock), .i_reset(reset), .i_start(start),
    .i_rx_data(rxData), .i_rx_valid(rxValid),
    .o_wr_enb_prog(wrEnB), .o_wr_addr(wrAddrB), .o_wr_data(wrDataB),
    .o_cpu_reset(cpuResetB), .o_busy(busyB), .o_done(doneB),
    .o_overflow(overflowB), .o_overrun(overrunB)
  );

  typedef struct packed {
    logic        wrEn;
    logic        busy;
    logic        done;
    logic        cpuReset;
    logic        overflow;
    logic        overrun;
    logic        checkAddr;
    logic [10:0] addr;
  } status_t;

  // Reference model state per instance (0: 2048 words, 1: 4 words).
  bit         loading[2];
  bit         haveHigh[2];
  bit         writing[2];
  bit         doneM[2];
  bit         ovfM[2];
  bit         ovrM[2];
  int         addrM[2];
  int         lastWord[2];
  logic [7:0] highM[2];
  logic [15:0] wordM[2];
  int         memWords[2] = '{2048, 4};

  status_t     stQ0[$];
  status_t     stQ1[$];
  logic [26:0] wrQ0[$];
  logic [26:0] wrQ1[$];

  // Predict the effect of one clock edge with the given inputs.
  task automatic modelStep(input int k, input bit rst, input bit st, input bit v, input logic [7:0] d);
    status_t s;
    logic [26:0] w;
    if (rst) begin
      loading[k] = 0; haveHigh[k] = 0; writing[k] = 0;
      doneM[k] = 0; ovfM[k] = 0; ovrM[k] = 0; addrM[k] = 0;
    end else if (writing[k]) begin
      writing[k] = 0;
      if (v) ovrM[k] = 1;
      if (wordM[k][15:11] == 5'd0) begin
        loading[k] = 0; doneM[k] = 1;
      end else if (addrM[k] == memWords[k] - 1) begin
        loading[k] = 0; doneM[k] = 1; ovfM[k] = 1;
      end else begin
        addrM[k] = addrM[k] + 1;
      end
    end else if (loading[k]) begin
      if (v) begin
        if (!haveHigh[k]) begin
          highM[k] = d; haveHigh[k] = 1;
        end else begin
          haveHigh[k] = 0;
          wordM[k] = {highM[k], d};
          writing[k] = 1;
          w = {11'(addrM[k]), wordM[k]};
          if (k == 0) wrQ0.push_back(w); else wrQ1.push_back(w);
        end
      end
    end else if (st) begin
      loading[k] = 1; haveHigh[k] = 0; doneM[k] = 0;
      addrM[k] = 0; ovfM[k] = 0; ovrM[k] = 0;
    end
    s.wrEn = writing[k];
    s.busy = loading[k];
    s.done = doneM[k];
    s.cpuReset = !doneM[k];
    s.overflow = ovfM[k];
    s.overrun = ovrM[k];
    s.checkAddr = rst;
    s.addr = 11'(addrM[k]);
    if (k == 0) stQ0.push_back(s); else stQ1.push_back(s);
  endtask

  // Drive one cycle of inputs on the falling edge and record predictions.
  task automatic applyStimulus(input bit rst, input bit st, input bit v, input logic [7:0] d);
    @(negedge clock);
    reset = rst; start = st; rxValid = v; rxData = d;
    modelStep(0, rst, st, v, d);
    modelStep(1, rst, st, v, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 8'h00);
  endtask

  task automatic sendByte(input logic [7:0] b);
    applyStimulus(0, 0, 1, b);
  endtask

  task automatic sendWord(input logic [15:0] w);
    sendByte(w[15:8]);
    sendByte(w[7:0]);
    idle(1);
  endtask

  task automatic compareStatus(input int k, input status_t exp, input status_t act);
    tests++;
    if (act[17:12] != exp[17:12] || (exp.checkAddr && act.addr != exp.addr)) begin
      failures++;
      $display("[TB] FAIL status%0d at %0t: got wr/busy/done/cpurst/ovf/ovr=%b addr=%0d, expected %b addr=%0d",
               k, $time, act[17:12], act.addr, exp[17:12], exp.addr);
    end
  endtask

  task automatic compareWrite(input int k, input logic [26:0] act);
    logic [26:0] exp;
    tests++;
    if (k == 0 && wrQ0.size() == 0 || k == 1 && wrQ1.size() == 0) begin
      failures++;
      $display("[TB] FAIL write%0d at %0t: unexpected write addr=%0d data=%h", k, $time, act[26:16], act[15:0]);
    end else begin
      exp = (k == 0) ? wrQ0.pop_front() : wrQ1.pop_front();
      if (act != exp) begin
        failures++;
        $display("[TB] FAIL write%0d at %0t: got addr=%0d data=%h, expected addr=%0d data=%h",
                 k, $time, act[26:16], act[15:0], exp[26:16], exp[15:0]);
      end
    end
  endtask

  // Sample both instances just after each rising edge.
  task automatic checkOutput();
    status_t a;
    if (stQ0.size() > 0) begin
      a = {wrEnA, busyA, doneA, cpuResetA, overflowA, overrunA, 1'b0, wrAddrA};
      compareStatus(0, stQ0.pop_front(), a);
    end
    if (stQ1.size() > 0) begin
      a = {wrEnB, busyB, doneB, cpuResetB, overflowB, overrunB, 1'b0, {9'd0, wrAddrB}};
      compareStatus(1, stQ1.pop_front(), a);
    end
    if (wrEnA === 1'b1) compareWrite(0, {wrAddrA, wrDataA});
    if (wrEnB === 1'b1) compareWrite(1, {9'd0, wrAddrB, wrDataB});
  endtask

  always @(posedge clock) begin
    #1;
    checkOutput();
  end

  initial begin
    logic [7:0] b;
    for (int k = 0; k < 2; k++) modelStep(k, 1, 0, 0, 8'h00);
    applyStimulus(1, 0, 0, 8'h00);
    idle(2);
    sendByte(8'h55);

    // Three instructions plus halt.
    applyStimulus(0, 1, 0, 8'h00);
    sendWord(16'h0805);
    sendWord(16'h1003);
    sendWord(16'h1801);
    sendWord(16'h0000);
    idle(3);

    // Five non-halt words: fills the 4-word instance, then a halt for the other.
    applyStimulus(0, 1, 0, 8'h00);
    for (int i = 0; i < 5; i++) sendWord(16'h0801);
    sendWord(16'h0000);
    idle(2);

    // Byte arriving on the write cycle is dropped.
    applyStimulus(0, 1, 0, 8'h00);
    sendByte(8'h08);
    sendByte(8'h05);
    sendByte(8'h77);
    sendWord(16'h1003);
    sendWord(16'h0000);
    idle(2);

    // Reset in the middle of a load, then a fresh halt-only load.
    applyStimulus(0, 1, 0, 8'h00);
    sendWord(16'h0805);
    sendByte(8'h10);
    applyStimulus(1, 0, 0, 8'h00);
    idle(2);
    applyStimulus(0, 1, 0, 8'h00);
    sendWord(16'h0000);
    idle(2);

    // Start while busy is ignored; start with a byte in DONE takes the start only.
    applyStimulus(0, 1, 1, 8'h12);
    sendByte(8'h08);
    applyStimulus(0, 1, 0, 8'h00);
    sendByte(8'h05);
    idle(1);
    sendWord(16'h0000);
    idle(2);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      b = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0,
                    $urandom_range(0, 1) == 1, b);
    end
    idle(3);
    @(negedge clock);

    tests++;
    if (wrQ0.size() != 0 || wrQ1.size() != 0) begin
      failures++;
      $display("[TB] FAIL pending writes: got %0d/%0d left, expected 0/0", wrQ0.size(), wrQ1.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
